// File: rtl/fib_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fib_sequencer
// Description : Accepts a Fibonacci job (seeds f0/f1, term index n_idx),
//               performs one add on a shared ALU per grant, and returns
//               F(n) mod 2^N over a valid/ready handshake with a sticky
//               overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_sequencer #(
  parameter int N     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     f0,
  input  logic [N-1:0]     f1,
  input  logic [CNT_W-1:0] n_idx,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     fn,
  output logic             ovf,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [2:0]       alu_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [N-1:0]     alu_y,
  input  logic             alu_cf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0]       C_OP_ADD  = 3'b000;
  localparam logic [CNT_W-1:0] C_REM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_a;      // F(k-2)
  logic [N-1:0]     r_b;      // F(k-1)
  logic [N-1:0]     r_fn;
  logic [CNT_W-1:0] r_rem;    // adds still to perform
  logic             r_ovf;
  logic             w_short;  // n_idx is 0 or 1: answer is a seed, no adds
  logic             w_last;   // granted add that completes the job

  assign w_short = (n_idx[CNT_W-1:1] == '0);
  assign w_last  = alu_gnt && (r_rem == C_REM_ONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start)     w_next = w_short ? S_HOLD : S_CALC;
      S_CALC: if (w_last)    w_next = S_HOLD;
      S_HOLD: if (out_ready) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // Datapath: seed latch on accept, one Fibonacci step per granted add
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_fn  <= '0;
      r_rem <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= f0;
            r_b   <= f1;
            r_ovf <= 1'b0;
            if (w_short) r_fn  <= n_idx[0] ? f1 : f0;
            else         r_rem <= n_idx - C_REM_ONE;
          end
        end
        S_CALC: begin
          if (alu_gnt) begin
            r_a   <= r_b;
            r_b   <= alu_y;
            r_ovf <= r_ovf | alu_cf;
            r_rem <= r_rem - C_REM_ONE;
            if (w_last) r_fn <= alu_y;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state; ALU operands are zeroed outside CALC
  always_comb begin
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_HOLD);
    alu_req   = (r_state == S_CALC);
    alu_op    = C_OP_ADD;
    alu_a     = alu_req ? r_a : '0;
    alu_b     = alu_req ? r_b : '0;
    fn        = r_fn;
    ovf       = r_ovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_fib_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_sequencer
// Description : Self-checking bench for fib_sequencer: vector table, random
//               jobs against an arithmetic Fibonacci model, and hand-written
//               reset / hold-handshake sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_sequencer;
  localparam int N     = 6;
  localparam int CNT_W = 8;
  localparam int MODV  = 1 << N;

  logic             clk;
  logic             reset;
  logic             start;
  logic [N-1:0]     f0;
  logic [N-1:0]     f1;
  logic [CNT_W-1:0] n_idx;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     fn;
  logic             ovf;
  logic             alu_req;
  logic             alu_gnt;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [N-1:0]     alu_y;
  logic             alu_cf;
  logic [N:0]       w_sum;

  fib_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .f0(f0), .f1(f1), .n_idx(n_idx),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .fn(fn), .ovf(ovf),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_y(alu_y), .alu_cf(alu_cf)
  );

  // Bench-side ALU: combinational unsigned add with carry-out
  assign w_sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_y  = w_sum[N-1:0];
  assign alu_cf = w_sum[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int f0; int f1; int n; int mode; int exp_fn; int exp_ovf;
  } vec_t;

  vec_t vecs[8];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: F(n) from seeds with plain integer arithmetic, wrap detection
  function automatic void fib_model(input int a0, input int b0, input int n,
                                    output int res, output int of);
    int a, b, s;
    a = a0; b = b0; of = 0;
    if (n == 0)      res = a0;
    else if (n == 1) res = b0;
    else begin
      for (int i = 2; i <= n; i++) begin
        s = a + b;
        if (s >= MODV) of = 1;
        a = b;
        b = s % MODV;
      end
      res = b;
    end
  endfunction

  // mode: 0 = grant every cycle, 1 = grant on odd cycles, 2 = random grant
  task automatic run_job(input int sf0, input int sf1, input int sn, input int mode,
                         input int exp_fn, input int exp_ovf, input bit do_release);
    int need, grants, l_exp, l_obs, req_cnt, ma, mb, s;
    bit g;
    need    = (sn < 2) ? 0 : sn - 1;
    grants  = 0;
    l_exp   = (sn < 2) ? 1 : -1;
    l_obs   = -1;
    req_cnt = 0;
    ma      = sf0;
    mb      = sf1;
    f0      = N'(sf0);
    f1      = N'(sf1);
    n_idx   = CNT_W'(sn);
    start   = 1'b1;
    tick;
    start   = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (out_valid) begin
        l_obs = k;
        break;
      end
      if (alu_req) req_cnt++;
      case (mode)
        0:       g = 1'b1;
        1:       g = ((k % 2) == 1);
        default: g = ($urandom_range(3) != 0);
      endcase
      alu_gnt = g;
      if (g && grants < need) begin
        chk("alu_a", alu_a, ma);
        chk("alu_b", alu_b, mb);
        s  = ma + mb;
        ma = mb;
        mb = s % MODV;
        grants++;
        if (grants == need) l_exp = k + 1;
      end
      tick;
    end
    alu_gnt = 1'b0;
    chk("latency", l_obs, l_exp);
    chk("fn", fn, exp_fn);
    chk("ovf", ovf, exp_ovf);
    chk("req_cycles", req_cnt, (sn < 2) ? 0 : l_exp - 1);
    if (l_obs < 0) begin
      reset = 1'b1;
      tick;
      reset = 1'b0;
    end else begin
      chk("hold_busy", busy, 1);
      chk("hold_req", alu_req, 0);
      if (do_release) begin
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_busy", busy, 0);
      end
    end
  endtask

  initial begin
    int rfn, rov, rf0, rf1, rn, hold_fn;

    vecs[0] = '{0, 1, 10, 0, 55, 0};
    vecs[1] = '{5, 7, 0, 0, 5, 0};
    vecs[2] = '{5, 7, 1, 0, 7, 0};
    vecs[3] = '{0, 1, 12, 0, 16, 1};
    vecs[4] = '{0, 1, 10, 1, 55, 0};
    vecs[5] = '{0, 1, 2, 0, 1, 0};
    vecs[6] = '{63, 63, 2, 0, 62, 1};
    vecs[7] = '{3, 4, 3, 1, 11, 0};

    reset = 1'b1; start = 1'b0; f0 = '0; f1 = '0; n_idx = '0;
    out_ready = 1'b0; alu_gnt = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fn", fn, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_req", alu_req, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_op", alu_op, 0);

    // Vector table
    foreach (vecs[i])
      run_job(vecs[i].f0, vecs[i].f1, vecs[i].n, vecs[i].mode,
              vecs[i].exp_fn, vecs[i].exp_ovf, 1'b1);

    // Reset mid-CALC after overflow has already been flagged
    f0 = 6'd0; f1 = 6'd1; n_idx = 8'd12; start = 1'b1;
    tick;
    start = 1'b0; alu_gnt = 1'b1;
    for (int k = 0; k < 10; k++) tick;
    chk("midcalc_ovf", ovf, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0; alu_gnt = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_fn", fn, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_req", alu_req, 0);
    chk("abort_a", alu_a, 0);
    tick;
    tick;
    chk("abort_no_valid", out_valid, 0);
    run_job(0, 1, 10, 0, 55, 0, 1'b1);

    // HOLD stalls with start pulses, then start+out_ready together is ignored
    run_job(0, 1, 5, 0, 5, 0, 1'b0);
    hold_fn = fn;
    for (int i = 0; i < 5; i++) begin
      start = ((i % 2) == 0); f0 = 6'd9; f1 = 6'd9; n_idx = 8'd3;
      tick;
      chk("hold_valid", out_valid, 1);
      chk("hold_fn_stable", fn, hold_fn);
      chk("hold_no_req", alu_req, 0);
    end
    start = 1'b1; out_ready = 1'b1;
    tick;
    start = 1'b0; out_ready = 1'b0;
    chk("exit_valid", out_valid, 0);
    chk("exit_busy", busy, 0);
    tick;
    chk("ignored_start", busy, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("ready_in_idle", busy, 0);
    run_job(2, 3, 4, 0, 13, 0, 1'b1);

    // Random jobs against the model
    for (int j = 0; j < 24; j++) begin
      rf0 = $urandom_range(MODV - 1);
      rf1 = $urandom_range(MODV - 1);
      rn  = $urandom_range(30);
      fib_model(rf0, rf1, rn, rfn, rov);
      run_job(rf0, rf1, rn, 2, rfn, rov, 1'b1);
    end
    fib_model(1, 2, 255, rfn, rov);
    run_job(1, 2, 255, 2, rfn, rov, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
